rv_muldiv_unit: RTL and testbench
=================================

# rv_muldiv_unit

Parametrised multi-cycle multiply/divide execute unit implementing the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide core. It sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time and holds the pipeline through `o_stall` while busy. It presents a registered result with a destination address and a one-cycle-per-result done strobe, and honours downstream stall and flush.

## Interface
Reset is asynchronous and active-high on `i_rst`; the block uses one clock, `i_clk`.

Parameters:
- `XLEN`, 32: operand/result width; legal values are 32 and 64.
- `MUL_LAT`, 2: cycles from accept to `o_done` for multiplies; legal range is 1..4.

Ports:
- `i_clk`, in, 1: clock, rising-edge active.
- `i_rst`, in, 1: asynchronous active-high reset.
- `i_start`, in, 1: request to start an operation (execute clock-enable qualified by M opcode).
- `i_funct3`, in, 3: operation select. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `i_rs1`, in, XLEN: operand A (dividend / multiplicand).
- `i_rs2`, in, XLEN: operand B (divisor / multiplier).
- `i_rd_addr`, in, 5: destination register address.
- `i_stall`, in, 1: downstream stage is stalled; hold the result.
- `i_flush`, in, 1: abort the in-flight operation.
- `o_stall`, out, 1: combinational request to stall the earlier stages.
- `o_done`, out, 1: `o_y` and `o_rd_addr` are valid.
- `o_y`, out, XLEN: result.
- `o_rd_addr`, out, 5: destination of the result.
- `o_busy`, out, 1: high when the state is MUL or DIV.

## Operation
- States:
  - IDLE.
  - MUL: counter runs to `MUL_LAT`.
  - DIV: counter runs to XLEN.
  - DONE.
- Accept rule: an operation is accepted when `i_start` is high, `i_flush` is low, and either the state is IDLE or the state is DONE with `i_stall` low.
  - On accept, the block latches `i_funct3`, `i_rs1`, `i_rs2` and `i_rd_addr`, and clears the counter.
- Accept transitions:
  - funct3 < 4 → MUL.
  - funct3 ≥ 4 with divisor zero, or signed overflow (funct3 4/6, rs1 = most negative value, rs2 = all-ones) → DONE directly (fast path).
  - All other funct3 ≥ 4 → DIV.
- Multiply:
  - The product is 2·XLEN bits wide.
  - Operands are sign-extended as follows: MULH both signed; MULHSU rs1 signed and rs2 unsigned; MULHU and MUL unsigned (MUL takes the low half).
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
  - Internal pipeline registers may be used, but the result is available in `o_y` exactly `MUL_LAT` cycles after accept.
- Divide:
  - Signed operations (4/6) take the operand magnitudes. The unit then runs restoring division, one quotient bit per cycle, for XLEN cycles.
  - Sign fix-up: the quotient is negated when the operand signs differ. The remainder takes the dividend's sign.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Fast-path results:
  - Divide by zero: quotient is all-ones; remainder equals rs1.
  - Overflow: quotient equals rs1; remainder is 0.
- DONE behaviour:
  - `o_done` is high and `o_y`/`o_rd_addr` are stable.
  - With `i_stall` high, the state holds.
  - With `i_stall` low, the state goes to IDLE, or to the next operation's state if one is accepted this cycle.
- `o_stall` = (`i_start` & !`i_flush` & state != DONE) | (state is MUL or DIV) | (state is DONE & `i_stall`).
- Flush: `i_flush` high in any state → IDLE at the next edge. `o_done` is low from that edge, and no result is produced for the aborted operation. `i_flush` overrides `i_start` in the same cycle.
- Reset: from any state, immediately go to IDLE and clear the counter. Reset values are `o_done` = 0, `o_y` = 0, `o_rd_addr` = 0, and `o_busy` = 0. `o_stall` follows its equation (0 while `i_start` is low).

## Timing
- Let the accept edge be cycle 0.
- Multiply: `o_done` rises at cycle `MUL_LAT`.
- Divide: the iterations occupy cycles 1..XLEN, and `o_done` rises at cycle XLEN+1 (33 for XLEN = 32).
- Fast path: `o_done` rises at cycle 1.
- `o_done` stays high for 1 cycle, plus 1 more cycle for each cycle `i_stall` is high while in DONE.
- Back-to-back operation: a new op accepted in DONE with `i_stall` low starts in the next cycle, with no idle bubble. `o_done` drops unless the new op is also DONE.
- Operand inputs are don't-care after the accept cycle.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), `MUL_LAT` = 2 → `o_y` = 0xFFFFFFEB, `o_done` at cycle 2, `o_stall` high in cycles 0–1.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, and REM → 0xFFFFFFFF; `o_done` at cycle 33; `o_rd_addr` = latched value.
- Fast path:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All at cycle 1.
- Flush and reset mid-operation:
  - `i_flush` at cycle 10 of a DIV → `o_done` never rises, `o_stall` is low at cycle 11, and a MUL accepted at cycle 11 completes correctly.
  - `i_rst` pulsed mid-DIV → all outputs return to 0 asynchronously.
- Hold and back-to-back: `i_stall` high for 3 cycles in DONE → `o_done`/`o_y` held for 4 cycles. A second op with `i_start` in the final cycle is accepted with no bubble.

Source files
------------

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: multi-cycle RISC-V M-extension execute unit.
// Multiplies finish MUL_LAT cycles after accept; divides use a restoring
// divider (one quotient bit per cycle) with a one-cycle fast path for
// divide-by-zero and signed overflow. The result sits in DONE until the
// downstream stage takes it.
module rv_muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_y,
    output logic [4:0]      o_rd_addr,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN + 1);
    // Counter value in the last MUL cycle (MUL state is skipped when MUL_LAT is 1)
    localparam logic [CW-1:0] MUL_LAST = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_y;
    logic [4:0]        r_rd;
    logic              r_done;

    // ---------------- accept and divide fast path ----------------
    logic              w_accept;
    logic              w_div_sgn;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_fast_y;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;

    assign w_accept   = i_start & ~i_flush &
                        ((r_state == S_IDLE) | ((r_state == S_DONE) & ~i_stall));
    assign w_div_sgn  = ~i_funct3[0];
    assign w_div_zero = (i_rs2 == '0);
    assign w_ovf      = w_div_sgn & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);
    // Zero divisor: q = all-ones, r = rs1. Overflow: q = rs1, r = 0.
    assign w_fast_y   = w_div_zero ? (i_funct3[1] ? i_rs1 : '1)
                                   : (i_funct3[1] ? '0    : i_rs1);
    assign w_a_neg    = w_div_sgn & i_rs1[XLEN-1];
    assign w_b_neg    = w_div_sgn & i_rs2[XLEN-1];
    assign w_a_mag    = w_a_neg ? -i_rs1 : i_rs1;
    assign w_b_mag    = w_b_neg ? -i_rs2 : i_rs2;

    // ---------------- multiplier ----------------
    // Operands come straight from the inputs on the accept cycle (needed when
    // MUL_LAT is 1) and from the latched copies while in MUL.
    logic              w_in_mul;
    logic [1:0]        w_m_op;
    logic [XLEN-1:0]   w_m_a;
    logic [XLEN-1:0]   w_m_b;
    logic              w_sx_a;
    logic              w_sx_b;
    logic [2*XLEN-1:0] w_ext_a;
    logic [2*XLEN-1:0] w_ext_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_y;

    assign w_in_mul = (r_state == S_MUL);
    assign w_m_op   = w_in_mul ? r_op  : i_funct3[1:0];
    assign w_m_a    = w_in_mul ? r_rs1 : i_rs1;
    assign w_m_b    = w_in_mul ? r_rs2 : i_rs2;
    assign w_sx_a   = (w_m_op == 2'd1) | (w_m_op == 2'd2);
    assign w_sx_b   = (w_m_op == 2'd1);
    // A 2*XLEN-bit product of sign/zero-extended operands is exact for all
    // mixed-sign cases, so a plain unsigned multiply suffices.
    assign w_ext_a  = {{XLEN{w_sx_a & w_m_a[XLEN-1]}}, w_m_a};
    assign w_ext_b  = {{XLEN{w_sx_b & w_m_b[XLEN-1]}}, w_m_b};
    assign w_prod   = w_ext_a * w_ext_b;
    assign w_mul_y  = (w_m_op == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // ---------------- restoring divider step ----------------
    // r_quo starts as the dividend magnitude; its bits shift out MSB-first
    // into the partial remainder while quotient bits shift in at the LSB.
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_quo_nx;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic [XLEN-1:0]   w_div_y;

    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    // The difference is below the divisor, so it fits in XLEN bits.
    assign w_rem_nx = w_ge ? (w_rem_sh[XLEN-1:0] - r_dvs) : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};
    assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_div_y  = r_op[1] ? w_r_fix : w_q_fix;

    // Control FSM, operand capture, iteration and result registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_y     <= '0;
            r_rd    <= '0;
            r_done  <= 1'b0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == MUL_LAST) begin
                        r_y     <= w_mul_y;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 1'b1;
                    // Last quotient bit and sign fix-up land on the same edge
                    if (r_cnt == DIV_LAST) begin
                        r_y     <= w_div_y;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!i_stall) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: ;
            endcase

            // A new op overrides the DONE->IDLE step (back-to-back, no bubble)
            if (w_accept) begin
                r_op    <= i_funct3[1:0];
                r_rs1   <= i_rs1;
                r_rs2   <= i_rs2;
                r_rd    <= i_rd_addr;
                r_cnt   <= '0;
                r_quo   <= w_a_mag;
                r_rem   <= '0;
                r_dvs   <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                if (!i_funct3[2]) begin
                    if (MUL_LAT == 1) begin
                        r_y     <= w_mul_y;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= S_MUL;
                    end
                end else if (w_div_zero | w_ovf) begin
                    r_y     <= w_fast_y;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end else begin
                    r_done  <= 1'b0;
                    r_state <= S_DIV;
                end
            end
        end
    end

    assign o_busy    = (r_state == S_MUL) | (r_state == S_DIV);
    assign o_stall   = (i_start & ~i_flush & (r_state != S_DONE)) | o_busy |
                       ((r_state == S_DONE) & i_stall);
    assign o_done    = r_done;
    assign o_y       = r_y;
    assign o_rd_addr = r_rd;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (XLEN=32, MUL_LAT=2): directed
// vectors with literal expectations, then random traffic compared every
// cycle against a transaction-level model (pending op + due edge).
module tb_rv_muldiv_unit;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        o_stall, o_done, o_busy;
    logic [31:0] o_y;
    logic [4:0]  o_rd_addr;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    rv_muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_funct3(funct3),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd_addr(rd_addr), .i_stall(stall),
        .i_flush(flush), .o_stall(o_stall), .o_done(o_done), .o_y(o_y),
        .o_rd_addr(o_rd_addr), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_y(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        logic ovf;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = signed'(a);
        ib = signed'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept to done
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 4) return MUL_LAT;
        if (b == 0) return 1;
        if ((f == 4 || f == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // ---------------- transaction-level model ----------------
    logic        m_done = 1'b0, m_pend = 1'b0;
    logic [31:0] m_y = '0, m_ry = '0;
    logic [4:0]  m_rd = '0, m_rrd = '0;
    longint      m_due = 0, ecnt = 0;

    always @(posedge clk or posedge rst) begin : model
        logic nd, np, acc;
        logic [31:0] ny, nry;
        logic [4:0] nrd, nrrd;
        longint ndue;
        int lat;
        if (rst) begin
            m_done <= 1'b0; m_pend <= 1'b0; m_y <= '0; m_rd <= '0; ecnt <= 0;
        end else begin
            nd = m_done; np = m_pend; ny = m_y; nrd = m_rd;
            nry = m_ry; nrrd = m_rrd; ndue = m_due;
            acc = start && !flush && ((!m_pend && !m_done) || (m_done && !stall));
            if (flush) begin
                nd = 1'b0; np = 1'b0;
            end else begin
                if (m_done && !stall) nd = 1'b0;
                if (m_pend && ecnt == m_due) begin
                    nd = 1'b1; ny = m_ry; nrd = m_rrd; np = 1'b0;
                end
                if (acc) begin
                    lat = ref_lat(funct3, rs1, rs2);
                    if (lat == 1) begin
                        nd = 1'b1; ny = ref_y(funct3, rs1, rs2); nrd = rd_addr;
                    end else begin
                        np = 1'b1; ndue = ecnt + lat - 1;
                        nry = ref_y(funct3, rs1, rs2); nrrd = rd_addr;
                    end
                end
            end
            m_done <= nd; m_pend <= np; m_y <= ny; m_rd <= nrd;
            m_ry <= nry; m_rrd <= nrrd; m_due <= ndue; ecnt <= ecnt + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("cyc_done", o_done, m_done);
            chk("cyc_busy", o_busy, m_pend);
            chk("cyc_stall", o_stall,
                (start && !flush && !m_done) || m_pend || (m_done && stall));
            if (m_done) begin
                chk("cyc_y", o_y, m_y);
                chk("cyc_rd", o_rd_addr, m_rd);
            end
        end
    end

    // Issue one op from IDLE and check result, destination and latency
    task automatic op(input string name, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_addr = rd;
        stall = 1'b0; flush = 1'b0;
        #1 chk({name, "_stall0"}, o_stall, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0; rs1 = $urandom; rs2 = $urandom; rd_addr = 5'($urandom);
            n++;
        end while (!o_done && n < 100);
        chk({name, "_lat"}, n, lat);
        chk({name, "_y"}, o_y, exp);
        chk({name, "_rd"}, o_rd_addr, rd);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            4: return 32'h0 - 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        // Reset state
        #12;
        chk("rst_done", o_done, 1'b0);
        chk("rst_y", o_y, 32'h0);
        chk("rst_rd", o_rd_addr, 5'h0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        start = 1'b1;
        #1 chk("rst_stall_eq", o_stall, 1'b1);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Model pins against hand-computed values
        chk("pin_mul", ref_y(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin_div", ref_y(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem", ref_y(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_mulhsu", ref_y(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

        // Directed vectors
        op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2);
        op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 2);
        op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 2);
        op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 2);
        op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, 33);
        op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 33);
        op("divu",   3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        33);
        op("remu",   3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         33);
        op("divu0",  3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1);
        op("remu0",  3'd7, 32'd5,          32'd0,         5'd10, 32'd5,         1);
        op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0,         1);

        // Hold in DONE for 3 stalled cycles, then back-to-back MUL
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0; rd_addr = 5'd13;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            stall = (c <= 3);
            #1;
            chk("hold_done", o_done, 1'b1);
            chk("hold_y", o_y, 32'hFFFF_FFFF);
            if (c == 4) begin
                start = 1'b1; funct3 = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; rd_addr = 5'd14;
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("b2b_drop", o_done, 1'b0);
        chk("b2b_busy", o_busy, 1'b1);
        @(negedge clk);
        #1;
        chk("b2b_done", o_done, 1'b1);
        chk("b2b_y", o_y, 32'hFFFF_FFEB);
        chk("b2b_rd", o_rd_addr, 5'd14);

        // Flush at cycle 10 of a DIV
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; rd_addr = 5'd15;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_stall", o_stall, 1'b0);
        chk("flush_done", o_done, 1'b0);
        chk("flush_busy", o_busy, 1'b0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done) seen++;
        end
        chk("flush_no_result", seen, 0);
        op("mul_after_flush", 3'd0, 32'd6, 32'd9, 5'd16, 32'd54, 2);

        // Asynchronous reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd17;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #3 rst = 1'b1;
        #1;
        chk("arst_done", o_done, 1'b0);
        chk("arst_y", o_y, 32'h0);
        chk("arst_rd", o_rd_addr, 5'h0);
        chk("arst_busy", o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        op("div_after_rst", 3'd4, 32'd100, 32'hFFFF_FFF9, 5'd18, 32'hFFFF_FFF2, 33);

        // Random traffic against the model
        seen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start   = ($urandom % 3) != 0;
            funct3  = 3'($urandom);
            rs1     = rnd_opnd();
            rs2     = rnd_opnd();
            rd_addr = 5'($urandom);
            stall   = ($urandom % 4) == 0;
            flush   = ($urandom % 50) == 0;
            if (o_done) seen++;
        end
        @(negedge clk);
        start = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (40) @(negedge clk);
        chk("rand_activity", seen > 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
